// File: rtl/systolic_operand_feeder_if.sv
// Host-load / PE-edge bundle of the systolic operand feeder.
interface systolic_operand_feeder_if #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int W = 32
);
    localparam int AW = (N * K > 1) ? $clog2(N * K) : 1;

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [N*W-1:0] a_out;
    logic [N-1:0]  a_valid;
    logic [N*W-1:0] b_out;
    logic [N-1:0]  b_valid;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, a_out, a_valid, b_out, b_valid
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, a_out, a_valid, b_out, b_valid
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Streams stored A rows / B columns into an N x N output-stationary PE array
// with diagonal skew; one registered lane per edge PE.
module systolic_operand_feeder_lane #(
    parameter int K   = 4,
    parameter int W   = 32,
    parameter int TW  = 4,
    parameter int OFF = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [TW-1:0]       t_nxt,
    input  logic [K-1:0][W-1:0] ops,
    output logic [W-1:0]        data,
    output logic                valid
);
    logic [W-1:0] d_nxt;
    logic         v_nxt;

    // Lane OFF sees operand k at feed cycle OFF+k, which produces the skew.
    always_comb begin
        d_nxt = '0;
        v_nxt = 1'b0;
        for (int k = 0; k < K; k++) begin
            if (load && t_nxt == TW'(OFF + k)) begin
                d_nxt = ops[k];
                v_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            data  <= d_nxt;
            valid <= v_nxt;
        end
    end
endmodule

module systolic_operand_feeder #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int W = 32
) (
    input logic                    clk,
    input logic                    rst,
    systolic_operand_feeder_if.slave io
);
    localparam int AW = (N * K > 1) ? $clog2(N * K) : 1;
    localparam int TW = $clog2(K + 2 * N);
    localparam logic [TW-1:0] T_FEED_END  = TW'(K + N - 2);
    localparam logic [TW-1:0] T_DRAIN_END = TW'(K + 2 * N - 3);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [TW-1:0] t, t_nxt;
    logic          busy_q, done_q;

    logic [N*K-1:0][W-1:0] a_mem, a_nxt, b_mem, b_nxt;
    logic                  wr_ok;
    logic [N-1:0][W-1:0]   a_dat, b_dat;
    logic [N-1:0]          a_vld, b_vld;

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            S_IDLE: if (io.start) begin
                state_nxt = S_FEED;
                t_nxt     = '0;
            end
            S_FEED: begin
                t_nxt = t + TW'(1);
                if (t == T_FEED_END) state_nxt = (N > 1) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                t_nxt = t + TW'(1);
                if (t == T_DRAIN_END) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                t_nxt     = '0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            t      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            t      <= t_nxt;
            busy_q <= (state_nxt == S_FEED) || (state_nxt == S_DRAIN);
            done_q <= (state_nxt == S_DONE);
        end
    end

    // Lanes read the post-write image so a write on the start edge reaches t=0.
    assign wr_ok = io.wr_en && (state == S_IDLE) &&
                   ({1'b0, io.wr_addr} < (AW + 1)'(N * K));

    always_comb begin
        a_nxt = a_mem;
        b_nxt = b_mem;
        if (wr_ok) begin
            if (io.wr_sel) b_nxt[io.wr_addr] = io.wr_data;
            else           a_nxt[io.wr_addr] = io.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        a_mem <= a_nxt;
        b_mem <= b_nxt;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [K-1:0][W-1:0] a_ops, b_ops;

        always_comb begin
            for (int k = 0; k < K; k++) begin
                a_ops[k] = a_nxt[i*K + k];
                b_ops[k] = b_nxt[k*N + i];
            end
        end

        systolic_operand_feeder_lane #(.K(K), .W(W), .TW(TW), .OFF(i)) u_a (
            .clk(clk), .rst(rst), .load(state_nxt == S_FEED), .t_nxt(t_nxt),
            .ops(a_ops), .data(a_dat[i]), .valid(a_vld[i])
        );

        systolic_operand_feeder_lane #(.K(K), .W(W), .TW(TW), .OFF(i)) u_b (
            .clk(clk), .rst(rst), .load(state_nxt == S_FEED), .t_nxt(t_nxt),
            .ops(b_ops), .data(b_dat[i]), .valid(b_vld[i])
        );
    end

    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.a_out   = a_dat;
    assign io.a_valid = a_vld;
    assign io.b_out   = b_dat;
    assign io.b_valid = b_vld;
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: a 2x2/K=2 instance and a 1x1/K=3 instance,
// a timeline model of both, small PE-array models and literal stream tables.
module tb_systolic_operand_feeder;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_operand_feeder_if #(.N(2), .K(2), .W(W)) io2 ();
    systolic_operand_feeder_if #(.N(1), .K(3), .W(W)) io1 ();

    systolic_operand_feeder #(.N(2), .K(2), .W(W)) dut2 (.clk(clk), .rst(rst), .io(io2));
    systolic_operand_feeder #(.N(1), .K(3), .W(W)) dut1 (.clk(clk), .rst(rst), .io(io1));

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endfunction

    // ---------------- timeline model (index 0 = 2x2 unit, 1 = 1x1 unit)
    int mn[2] = '{2, 1};
    int mk[2] = '{2, 3};
    int ma[2][16];
    int mb[2][16];
    int run[2] = '{-1, -1};   // feed cycle t of the current run, -1 when idle

    logic in_we[2], in_sel[2], in_st[2];
    int   in_ad[2], in_dt[2];
    logic [2*W-1:0] act_a[2], act_b[2];
    logic [1:0]     act_av[2], act_bv[2];
    logic           act_busy[2], act_done[2];

    assign in_we[0] = io2.wr_en;  assign in_we[1] = io1.wr_en;
    assign in_sel[0] = io2.wr_sel; assign in_sel[1] = io1.wr_sel;
    assign in_st[0] = io2.start;  assign in_st[1] = io1.start;
    assign in_ad[0] = int'(io2.wr_addr); assign in_ad[1] = int'(io1.wr_addr);
    assign in_dt[0] = int'(io2.wr_data); assign in_dt[1] = int'(io1.wr_data);
    assign act_a[0] = io2.a_out;  assign act_a[1] = {{W{1'b0}}, io1.a_out};
    assign act_b[0] = io2.b_out;  assign act_b[1] = {{W{1'b0}}, io1.b_out};
    assign act_av[0] = io2.a_valid; assign act_av[1] = {1'b0, io1.a_valid};
    assign act_bv[0] = io2.b_valid; assign act_bv[1] = {1'b0, io1.b_valid};
    assign act_busy[0] = io2.busy; assign act_busy[1] = io1.busy;
    assign act_done[0] = io2.done; assign act_done[1] = io1.done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            run[0] <= -1;
            run[1] <= -1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (run[d] < 0) begin
                    if (in_we[d] && in_ad[d] < mn[d] * mk[d]) begin
                        if (in_sel[d]) mb[d][in_ad[d]] <= in_dt[d];
                        else           ma[d][in_ad[d]] <= in_dt[d];
                    end
                    if (in_st[d]) run[d] <= 0;
                end else if (run[d] >= mk[d] + 2 * mn[d] - 2) begin
                    run[d] <= -1;
                end else begin
                    run[d] <= run[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int r, n, k, s, ea, eb;
        logic v;
        for (int d = 0; d < 2; d++) begin
            r = run[d]; n = mn[d]; k = mk[d];
            chk($sformatf("mdl d%0d busy t=%0d", d, r), W'(act_busy[d]), W'(r >= 0 && r <= k + 2 * n - 3));
            chk($sformatf("mdl d%0d done t=%0d", d, r), W'(act_done[d]), W'(r == k + 2 * n - 2));
            for (int i = 0; i < n; i++) begin
                s = r - i;
                v = (r >= 0 && s >= 0 && s < k);
                ea = 0; eb = 0;
                if (v) begin
                    ea = ma[d][i*k + s];
                    eb = mb[d][s*n + i];
                end
                chk($sformatf("mdl d%0d a_valid[%0d] t=%0d", d, i, r), W'(act_av[d][i]), W'(v));
                chk($sformatf("mdl d%0d a_out[%0d] t=%0d", d, i, r), act_a[d][i*W +: W], W'(ea));
                chk($sformatf("mdl d%0d b_valid[%0d] t=%0d", d, i, r), W'(act_bv[d][i]), W'(v));
                chk($sformatf("mdl d%0d b_out[%0d] t=%0d", d, i, r), act_b[d][i*W +: W], W'(eb));
            end
        end
    end

    // ---------------- PE array models fed by the DUT edges
    int ar[2][2], br[2][2], acc2[2][2];
    logic avr[2][2], bvr[2][2];
    int acc1;

    always @(posedge clk or negedge rst) begin
        int ai, bi;
        logic av, bv;
        if (!rst || (!io2.busy && !io2.done)) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    ar[i][j] <= 0; br[i][j] <= 0; acc2[i][j] <= 0;
                    avr[i][j] <= 1'b0; bvr[i][j] <= 1'b0;
                end
        end else begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    ai = (j == 0) ? int'(io2.a_out[i*W +: W]) : ar[i][j-1];
                    av = (j == 0) ? io2.a_valid[i] : avr[i][j-1];
                    bi = (i == 0) ? int'(io2.b_out[j*W +: W]) : br[i-1][j];
                    bv = (i == 0) ? io2.b_valid[j] : bvr[i-1][j];
                    ar[i][j] <= ai; avr[i][j] <= av;
                    br[i][j] <= bi; bvr[i][j] <= bv;
                    if (av && bv) acc2[i][j] <= acc2[i][j] + ai * bi;
                end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst || (!io1.busy && !io1.done)) acc1 <= 0;
        else if (io1.a_valid[0] && io1.b_valid[0]) acc1 <= acc1 + int'(io1.a_out) * int'(io1.b_out);
    end

    // ---------------- stimulus (tasks start and end #1 after a rising edge)
    task automatic wr2(input logic sel, input int addr, input int data);
        io2.wr_en = 1'b1; io2.wr_sel = sel; io2.wr_addr = addr[1:0]; io2.wr_data = W'(data);
        @(posedge clk); #1;
        io2.wr_en = 1'b0;
    endtask

    task automatic wr1(input logic sel, input int addr, input int data);
        io1.wr_en = 1'b1; io1.wr_sel = sel; io1.wr_addr = addr[1:0]; io1.wr_data = W'(data);
        @(posedge clk); #1;
        io1.wr_en = 1'b0;
    endtask

    // act: 0 plain, 1 start+write during feed and start in DONE, 2 reset at t=1,
    // 3 write A[0][1]=9 on the start edge
    task automatic run2(input int act);
        int la0[5] = '{1, 2, 0, 0, 0};
        int la1[5] = '{0, 3, 4, 0, 0};
        int lb0[5] = '{5, 7, 0, 0, 0};
        int lb1[5] = '{0, 6, 8, 0, 0};
        int lbusy[5] = '{1, 1, 1, 1, 0};
        if (act == 3) la0[1] = 9;
        io2.start = 1'b1;
        if (act == 3) begin
            io2.wr_en = 1'b1; io2.wr_sel = 1'b0; io2.wr_addr = 2'd1; io2.wr_data = W'(9);
        end
        @(posedge clk); #1;
        io2.start = 1'b0; io2.wr_en = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
                io2.start = 1'b0; io2.wr_en = 1'b0;
            end
            if (t == 1 && act == 1) begin
                io2.start = 1'b1;
                io2.wr_en = 1'b1; io2.wr_sel = 1'b0; io2.wr_addr = 2'd0; io2.wr_data = W'(99);
            end
            if (t == 4 && act == 1) io2.start = 1'b1;
            if (t == 1 && act == 2) rst = 1'b0;
            @(negedge clk);
            if (t == 1 && act == 2) begin
                chk("lit rst a_out", io2.a_out[W-1:0] | io2.a_out[2*W-1:W], '0);
                chk("lit rst b_out", io2.b_out[W-1:0] | io2.b_out[2*W-1:W], '0);
                chk("lit rst valids", W'({io2.a_valid, io2.b_valid}), '0);
                chk("lit rst busy/done", W'({io2.busy, io2.done}), '0);
                break;
            end
            chk($sformatf("lit a0 t=%0d", t), io2.a_out[0 +: W], W'(la0[t]));
            chk($sformatf("lit a1 t=%0d", t), io2.a_out[W +: W], W'(la1[t]));
            chk($sformatf("lit b0 t=%0d", t), io2.b_out[0 +: W], W'(lb0[t]));
            chk($sformatf("lit b1 t=%0d", t), io2.b_out[W +: W], W'(lb1[t]));
            chk($sformatf("lit valids t=%0d", t), W'({io2.a_valid, io2.b_valid}),
                W'({la1[t] != 0, la0[t] != 0, lb1[t] != 0, lb0[t] != 0}));
            chk($sformatf("lit busy t=%0d", t), W'(io2.busy), W'(lbusy[t]));
            chk($sformatf("lit done t=%0d", t), W'(io2.done), W'(t == 4));
            if (t == 4) begin
                chk("lit C00", W'(acc2[0][0]), W'((act == 3) ? 68 : 19));
                chk("lit C01", W'(acc2[0][1]), W'((act == 3) ? 78 : 22));
                chk("lit C10", W'(acc2[1][0]), W'(43));
                chk("lit C11", W'(acc2[1][1]), W'(50));
            end
        end
        @(posedge clk); #1;
        io2.start = 1'b0; io2.wr_en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic run1();
        int la[4] = '{2, 3, 4, 0};
        int lb[4] = '{5, 6, 7, 0};
        io1.start = 1'b1;
        @(posedge clk); #1;
        io1.start = 1'b0;
        for (int t = 0; t <= 3; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk($sformatf("lit1 a t=%0d", t), io1.a_out, W'(la[t]));
            chk($sformatf("lit1 b t=%0d", t), io1.b_out, W'(lb[t]));
            chk($sformatf("lit1 valids t=%0d", t), W'({io1.a_valid, io1.b_valid}), W'((t < 3) ? 3 : 0));
            chk($sformatf("lit1 busy/done t=%0d", t), W'({io1.busy, io1.done}), W'((t < 3) ? 2 : 1));
        end
        chk("lit1 acc", W'(acc1), W'(56));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        io2.wr_en = 1'b0; io2.wr_sel = 1'b0; io2.wr_addr = '0; io2.wr_data = '0; io2.start = 1'b0;
        io1.wr_en = 1'b0; io1.wr_sel = 1'b0; io1.wr_addr = '0; io1.wr_data = '0; io1.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit reset outs2", io2.a_out[W-1:0] | io2.a_out[2*W-1:W] | io2.b_out[W-1:0] | io2.b_out[2*W-1:W], '0);
        chk("lit reset ctl2", W'({io2.busy, io2.done, io2.a_valid, io2.b_valid}), '0);
        chk("lit reset outs1", io1.a_out | io1.b_out, '0);
        chk("lit reset ctl1", W'({io1.busy, io1.done, io1.a_valid, io1.b_valid}), '0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wr2(1'b0, i, i + 1);      // A = [[1,2],[3,4]]
            wr2(1'b1, i, i + 5);      // B = [[5,6],[7,8]]
        end
        for (int i = 0; i < 3; i++) begin
            wr1(1'b0, i, i + 2);      // A = [2,3,4]
            wr1(1'b1, i, i + 5);      // B = [5,6,7]
        end
        wr1(1'b0, 3, 77);             // out of range, dropped

        run2(0);
        run2(1);
        run2(0);
        run2(2);
        run2(0);
        run2(3);
        run1();
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
